i2s_tx_axi4_lite_slave_regs: RTL

AXI4-Lite responder (slave) end of the I2S transmitter control bus. It accepts register reads and writes from the s_axi_ctrl_* master and holds the I2S TX control/configuration registers. It drives static configuration to the I2S TX core and reads back its live status. It sits between the AXI4-Lite interconnect and the I2S TX serializer/clock generator.

---
 rtl/i2s_tx_axi4_lite_slave_regs_if.sv | 30 +++
 rtl/i2s_tx_axi4_lite_slave_regs.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_axi4_lite_slave_regs_if.sv
// AXI4-Lite control-bus bundle for the I2S TX register block.
// Carries the five AXI4-Lite channels; clock and reset stay outside the bundle.
interface i2s_tx_axi4_lite_slave_regs_if;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/i2s_tx_axi4_lite_slave_regs.sv
// AXI4-Lite register block for the I2S transmitter: config out, live status in.
// Optional interrupt logic (IRQ_EN / IRQ_STS / irq) is enabled by I2S_TX_AXI_IRQ_EN.
module i2s_tx_axi4_lite_slave_regs #(
  parameter logic [31:0] VERSION        = 32'h0001_0000,
  parameter int unsigned DATA_WIDTH_CFG = 24,
  parameter int unsigned NUM_CHANNELS   = 2
) (
  input  logic                                s_axi_ctrl_aclk,
  input  logic                                s_axi_ctrl_aresetn,
  i2s_tx_axi4_lite_slave_regs_if.slave        s_axi_ctrl,
  output logic                                tx_en,
  output logic                                soft_rst,
  output logic [7:0]                          sclk_div,
  input  logic                                tx_busy,
`ifdef I2S_TX_AXI_IRQ_EN
  input  logic                                underrun,
  output logic                                irq
`else
  input  logic                                underrun
`endif
);

  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // Word indices (byte address [7:2]).
  localparam logic [5:0] IdxVersion = 6'h00;
  localparam logic [5:0] IdxConfig  = 6'h01;
  localparam logic [5:0] IdxControl = 6'h02;
  localparam logic [5:0] IdxStatus  = 6'h03;
  localparam logic [5:0] IdxTiming  = 6'h04;
`ifdef I2S_TX_AXI_IRQ_EN
  localparam logic [5:0] IdxIrqEn   = 6'h05;
  localparam logic [5:0] IdxIrqSts  = 6'h06;
`endif

  localparam logic [5:0]  DwCfg     = 6'(DATA_WIDTH_CFG);
  localparam logic [3:0]  NumCh     = 4'(NUM_CHANNELS);
  localparam logic [31:0] ConfigVal = {20'b0, NumCh, 2'b0, DwCfg};

  typedef enum logic [1:0] {WrIdle, WrGotAddr, WrGotData, WrResp} wr_state_e;
  typedef enum logic {RdIdle, RdResp} rd_state_e;

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;

  // Holds readies low until the first clock edge after reset is released.
  logic        rst_done_q;
  logic [5:0]  awidx_q;
  logic [31:0] wdata_q;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        tx_en_q;
  logic        soft_rst_q;
  logic [7:0]  sclk_div_q;

  logic        aw_fire, w_fire, ar_fire;
  logic        wr_commit;
  logic [5:0]  wr_idx;
  logic [31:0] wr_data;
  logic        wr_ok;
  logic [31:0] rd_word;
  logic        rd_ok;

`ifdef I2S_TX_AXI_IRQ_EN
  logic        irq_en_q;
  logic        irq_sts_q;
  logic        irq_q;
`endif

  assign s_axi_ctrl.awready = rst_done_q && (wr_state_q == WrIdle || wr_state_q == WrGotData);
  assign s_axi_ctrl.wready  = rst_done_q && (wr_state_q == WrIdle || wr_state_q == WrGotAddr);
  assign s_axi_ctrl.bvalid  = (wr_state_q == WrResp);
  assign s_axi_ctrl.bresp   = bresp_q;
  assign s_axi_ctrl.arready = rst_done_q && (rd_state_q == RdIdle);
  assign s_axi_ctrl.rvalid  = (rd_state_q == RdResp);
  assign s_axi_ctrl.rdata   = rdata_q;
  assign s_axi_ctrl.rresp   = rresp_q;

  assign aw_fire = s_axi_ctrl.awvalid && s_axi_ctrl.awready;
  assign w_fire  = s_axi_ctrl.wvalid && s_axi_ctrl.wready;
  assign ar_fire = s_axi_ctrl.arvalid && s_axi_ctrl.arready;

  assign tx_en    = tx_en_q;
  assign soft_rst = soft_rst_q;
  assign sclk_div = sclk_div_q;

  // Write FSM: the commit address/data come from the bus or the latched half.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_commit  = 1'b0;
    wr_idx     = s_axi_ctrl.awaddr[7:2];
    wr_data    = s_axi_ctrl.wdata;
    unique case (wr_state_q)
      WrIdle: begin
        if (aw_fire && w_fire) begin
          wr_commit  = 1'b1;
          wr_state_d = WrResp;
        end else if (aw_fire) begin
          wr_state_d = WrGotAddr;
        end else if (w_fire) begin
          wr_state_d = WrGotData;
        end
      end
      WrGotAddr: begin
        wr_idx = awidx_q;
        if (w_fire) begin
          wr_commit  = 1'b1;
          wr_state_d = WrResp;
        end
      end
      WrGotData: begin
        wr_data = wdata_q;
        if (aw_fire) begin
          wr_commit  = 1'b1;
          wr_state_d = WrResp;
        end
      end
      WrResp: begin
        if (s_axi_ctrl.bready) wr_state_d = WrIdle;
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RdIdle:  if (ar_fire) rd_state_d = RdResp;
      RdResp:  if (s_axi_ctrl.rready) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    wr_ok = 1'b1;
    case (wr_idx)
      IdxVersion, IdxConfig, IdxControl, IdxStatus, IdxTiming: wr_ok = 1'b1;
`ifdef I2S_TX_AXI_IRQ_EN
      IdxIrqEn, IdxIrqSts: wr_ok = 1'b1;
`endif
      default: wr_ok = 1'b0;
    endcase
  end

  // Read mux sees pre-write register values, so a same-edge write is not visible.
  always_comb begin
    rd_word = '0;
    rd_ok   = 1'b1;
    case (s_axi_ctrl.araddr[7:2])
      IdxVersion: rd_word = VERSION;
      IdxConfig:  rd_word = ConfigVal;
      IdxControl: rd_word = {31'b0, tx_en_q};
      IdxStatus:  rd_word = {31'b0, tx_busy};
      IdxTiming:  rd_word = {24'b0, sclk_div_q};
`ifdef I2S_TX_AXI_IRQ_EN
      IdxIrqEn:   rd_word = {31'b0, irq_en_q};
      IdxIrqSts:  rd_word = {31'b0, irq_sts_q};
`endif
      default:    rd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (!s_axi_ctrl_aresetn) begin
      rst_done_q <= 1'b0;
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      awidx_q    <= '0;
      wdata_q    <= '0;
      bresp_q    <= RespOkay;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      tx_en_q    <= 1'b0;
      soft_rst_q <= 1'b0;
      sclk_div_q <= '0;
    end else begin
      rst_done_q <= 1'b1;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      if (aw_fire) awidx_q <= s_axi_ctrl.awaddr[7:2];
      if (w_fire) wdata_q <= s_axi_ctrl.wdata;
      if (wr_commit) bresp_q <= wr_ok ? RespOkay : RespSlvErr;
      if (ar_fire) begin
        rdata_q <= rd_word;
        rresp_q <= rd_ok ? RespOkay : RespSlvErr;
      end
      soft_rst_q <= wr_commit && (wr_idx == IdxControl) && wr_data[1];
      if (wr_commit && wr_idx == IdxControl) tx_en_q <= wr_data[0];
      if (wr_commit && wr_idx == IdxTiming) sclk_div_q <= wr_data[7:0];
    end
  end

`ifdef I2S_TX_AXI_IRQ_EN
  // Sticky underrun flag: a same-edge set beats the W1C clear.
  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (!s_axi_ctrl_aresetn) begin
      irq_en_q  <= 1'b0;
      irq_sts_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_commit && wr_idx == IdxIrqEn) irq_en_q <= wr_data[0];
      if (underrun) begin
        irq_sts_q <= 1'b1;
      end else if (wr_commit && wr_idx == IdxIrqSts && wr_data[0]) begin
        irq_sts_q <= 1'b0;
      end
      irq_q <= irq_en_q & irq_sts_q;
    end
  end

  assign irq = irq_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{s_axi_ctrl.awaddr[1:0], s_axi_ctrl.araddr[1:0], wr_data[31:8],
                         underrun};

endmodule
